sram_spi_arbiter: RTL and testbench

//  Shares one SPI SRAM byte engine between two requesters (port 0: Pi host, port 1: accelerator).

---
 rtl/sram_spi_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/sram_spi_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_spi_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_spi_pkg.sv
// Shared opcodes, FSM state type and a small helper for the SPI SRAM arbiter.
package sram_spi_pkg;

  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND,
    GAP
  } arb_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant_o holds the most recently granted port.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       last_grant_o,
  output logic       gnt_idx_o
);

  logic last_q;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    gnt_idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (grant_en_i && (req_i != 2'b00)) begin
      last_q <= gnt_idx_o;
    end
  end

  assign last_grant_o = last_q;

endmodule

// File: rtl/sram_spi_arbiter.sv
// Round-robin front end for one SPI SRAM byte engine: issues a one-cycle opcode strobe,
// waits for done or timeout, acks the granted port and enforces idle gaps between ops.
module sram_spi_arbiter
  import sram_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DRAIN_CYCLES   = 48,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  eng_inst,
  output logic [23:0] eng_addr,
  output logic [7:0]  eng_wdata,
  input  logic [7:0]  eng_rdata,
  input  logic        eng_done
);

  localparam int unsigned CW = $clog2(max2(TIMEOUT_CYCLES, DRAIN_CYCLES) + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          grant_en;
  logic          gnt_idx;
  logic          last_grant;
  logic [CW-1:0] gap_last;

  rr_arb2 u_rr_arb2 (
    .clk_i        (sclk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .grant_en_i   (grant_en),
    .last_grant_o (last_grant),
    .gnt_idx_o    (gnt_idx)
  );

  // A timed-out engine may still be mid-transfer, so it gets the full drain time.
  assign gap_last = err_q ? CW'(DRAIN_CYCLES - 1) : CW'(GAP_CYCLES - 1);

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    grant_en = 1'b0;
    unique case (state_q)
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (req != 2'b00) begin
          grant_en = 1'b1;
          we_d     = we[gnt_idx];
          addr_d   = gnt_idx ? addr1 : addr0;
          wdata_d  = gnt_idx ? wdata1 : wdata0;
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CW'(1);
        if (eng_done) begin
          if (!we_q) begin
            rdata_d = eng_rdata;
          end
          state_d = RESPOND;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == gap_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DRAIN;
      end
    endcase
  end

  // last_grant still names the granted port until the next grant in IDLE.
  always_comb begin
    eng_inst = OP_IDLE;
    ack      = 2'b00;
    err      = 1'b0;
    busy     = (state_q != IDLE);
    if (state_q == ISSUE) begin
      eng_inst = we_q ? OP_WRITE : OP_READ;
    end
    if (state_q == RESPOND) begin
      ack[last_grant] = 1'b1;
      err             = err_q;
    end
  end

  assign rdata     = rdata_q;
  assign eng_addr  = addr_q;
  assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_sram_spi_arbiter.sv
// Self-checking bench: engine BFM, transaction-level scoreboard, directed table and random traffic.
module tb_sram_spi_arbiter;

  localparam int TO  = 64;
  localparam int DR  = 48;
  localparam int GP  = 2;
  localparam int LAT = 44;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  eng_inst;
  logic [23:0] eng_addr;
  logic [7:0]  eng_wdata;
  logic [7:0]  eng_rdata = '0;
  logic        eng_done = 1'b0;

  assign req = {req1, req0};

  always #5 sclk = ~sclk;

  sram_spi_arbiter dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .req       (req),
    .we        ({we1, we0}),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .eng_inst  (eng_inst),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_rdata (eng_rdata),
    .eng_done  (eng_done)
  );

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Engine memory contents as seen by reads.
  function automatic logic [7:0] rd_fn(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
  endfunction

  // Scoreboard state.
  int          cyc = 0;
  int          min_start = 0;
  bit          out_v = 0;
  int          out_port = 0;
  bit          out_we = 0;
  bit          out_hang = 0;
  logic [23:0] out_addr = '0;
  logic [7:0]  out_wd = '0;
  logic [7:0]  out_rd = '0;
  int          strobe_cyc = 0;
  bit          m_last = 1;
  logic [7:0]  m_rdata = '0;
  bit          prev_strobe = 0;
  bit          rand_hang_en = 0;
  bit          force_hang = 0;
  bit          stray = 0;
  int          ack_log[$];

  always @(posedge sclk) begin : monitor
    logic [1:0]  rq;
    logic [1:0]  wq;
    logic [23:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        rs;
    int          w;
    bit          exp_busy;
    rq = req; wq = {we1, we0}; a0 = addr0; a1 = addr1; d0 = wdata0; d1 = wdata1; rs = rst_n;
    cyc++;
    #1;
    if (!rs) begin
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_eng_inst", eng_inst, 0);
      chk("rst_eng_addr", eng_addr, 0);
      chk("rst_eng_wdata", eng_wdata, 0);
      chk("rst_busy", busy, 1);
      out_v = 0; m_last = 1; m_rdata = '0; min_start = cyc + DR + 1;
    end else begin
      if (eng_inst != 8'h00) begin
        chk("strobe_single", prev_strobe, 0);
        chk("strobe_spacing", cyc >= min_start, 1);
        chk("strobe_has_req", rq != 2'b00, 1);
        w = (rq == 2'b11) ? int'(!m_last) : int'(rq[1]);
        m_last = (w == 1);
        out_port = w;
        out_we = wq[w];
        out_addr = (w == 1) ? a1 : a0;
        out_wd = (w == 1) ? d1 : d0;
        chk("eng_inst", eng_inst, out_we ? 32'h02 : 32'h03);
        chk("eng_addr", eng_addr, out_addr);
        if (out_we) chk("eng_wdata", eng_wdata, out_wd);
        out_hang = force_hang || (rand_hang_en && ($urandom_range(0, 7) == 0));
        out_rd = rd_fn(out_addr);
        out_v = 1;
        strobe_cyc = cyc;
      end else if (out_v) begin
        if (eng_addr !== out_addr) chk("eng_addr_hold", eng_addr, out_addr);
        if (out_we && eng_wdata !== out_wd) chk("eng_wdata_hold", eng_wdata, out_wd);
      end
      if (ack !== 2'b00) begin
        if (!out_v) begin
          chk("ack_unexpected", ack, 0);
        end else begin
          chk("ack_port", ack, 32'd1 << out_port);
          chk("ack_err", err, out_hang);
          chk("ack_latency", cyc - strobe_cyc, out_hang ? TO + 1 : LAT);
          if (!out_we && !out_hang) m_rdata = out_rd;
          chk("ack_rdata", rdata, m_rdata);
          out_v = 0;
          min_start = cyc + (out_hang ? DR : GP) + 2;
        end
        ack_log.push_back((ack == 2'b10) ? 1 : 0);
      end else begin
        if (err !== 1'b0) chk("err_without_ack", err, 0);
        if (rdata !== m_rdata) chk("rdata_hold", rdata, m_rdata);
      end
      exp_busy = out_v || (cyc < min_start - 1);
      if (busy !== exp_busy) chk("busy", busy, exp_busy);
    end
    prev_strobe = (eng_inst != 8'h00);
  end

  // Engine BFM: done 43 cycles after a strobe unless the scoreboard chose a hang.
  bit          pend = 0;
  int          due = 0;
  logic [7:0]  bdat = '0;
  always @(negedge sclk) begin
    if (eng_inst != 8'h00 && !out_hang) begin
      pend = 1; due = cyc + LAT - 1; bdat = rd_fn(eng_addr);
    end
    if (pend && cyc == due) begin
      eng_done = 1'b1; eng_rdata = bdat; pend = 0;
    end else begin
      eng_done = stray; eng_rdata = 8'($urandom);
    end
  end

  task automatic port_txn(input int p, input logic w, input logic [23:0] a, input logic [7:0] d,
                          output bit got, output logic e, output logic [7:0] rd);
    @(negedge sclk);
    if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    got = 0; e = 1'bx; rd = 'x;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge sclk); #1;
      if (ack[p]) begin got = 1; e = err; rd = rdata; end
    end
    if (!got) chk("ack_wait", got, 1);
    @(negedge sclk);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    bit          hang;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vec[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    bit          g, g0, g1;
    logic        e, e0, e1;
    logic [7:0]  r, r0, r1;
    int          base;
    bit          seen;

    vec[0] = '{0, 1'b0, 24'h000123, 8'h00, 0, 1'b0, 8'hA5};
    vec[1] = '{1, 1'b1, 24'hFFFFFF, 8'h3C, 0, 1'b0, 8'hA5};
    vec[2] = '{0, 1'b0, 24'hABCDEF, 8'h00, 0, 1'b0, rd_fn(24'hABCDEF)};
    vec[3] = '{1, 1'b0, 24'h800000, 8'h00, 1, 1'b1, rd_fn(24'hABCDEF)};
    vec[4] = '{0, 1'b0, 24'h000000, 8'h00, 0, 1'b0, 8'h87};
    vec[5] = '{1, 1'b0, 24'h5A5A5A, 8'h00, 0, 1'b0, rd_fn(24'h5A5A5A)};
    vec[6] = '{0, 1'b1, 24'h123456, 8'hFF, 0, 1'b0, rd_fn(24'h5A5A5A)};
    vec[7] = '{1, 1'b1, 24'h000001, 8'h01, 0, 1'b0, rd_fn(24'h5A5A5A)};

    repeat (3) @(negedge sclk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      force_hang = vec[i].hang;
      port_txn(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, g, e, r);
      chk("tbl_ack", g, 1);
      chk("tbl_err", e, vec[i].err);
      chk("tbl_rdata", r, vec[i].rdata);
    end
    force_hang = 0;

    // Both ports back to back: grants must alternate starting with port 0.
    base = ack_log.size();
    fork
      begin
        for (int k = 0; k < 4; k++) port_txn(0, 1'b0, 24'h000100 + 24'(k), 8'h00, g0, e0, r0);
      end
      begin
        for (int k = 0; k < 4; k++) port_txn(1, 1'b1, 24'h000200 + 24'(k), 8'h10 + 8'(k), g1, e1, r1);
      end
    join
    chk("rr_count", ack_log.size() - base, 8);
    for (int k = 0; k < 8 && base + k < ack_log.size(); k++) chk("rr_order", ack_log[base + k], k % 2);

    // Reset during WAIT_DONE drops the transaction and restores port-0 priority.
    @(negedge sclk);
    we0 = 1'b0; addr0 = 24'h000777; req0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge sclk); #1;
      if (eng_inst != 8'h00) seen = 1;
    end
    chk("rst_strobe_seen", seen, 1);
    repeat (20) @(negedge sclk);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    base = ack_log.size();
    repeat (60) @(negedge sclk);
    chk("rst_no_ack", ack_log.size(), base);
    fork
      port_txn(0, 1'b0, 24'h000010, 8'h00, g0, e0, r0);
      port_txn(1, 1'b0, 24'h000020, 8'h00, g1, e1, r1);
    join
    chk("rst_tie_count", ack_log.size() - base, 2);
    if (ack_log.size() > base) chk("rst_tie_port0", ack_log[base], 0);

    // Stray done while idle produces no ack.
    base = ack_log.size();
    repeat (5) @(negedge sclk);
    @(posedge sclk); #2; stray = 1;
    @(posedge sclk); #2; stray = 0;
    repeat (5) @(negedge sclk);
    chk("stray_no_ack", ack_log.size(), base);

    // Request dropped right after grant still completes.
    @(negedge sclk);
    we1 = 1'b0; addr1 = 24'h0ABCDE; req1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge sclk); #1;
      if (eng_inst != 8'h00) seen = 1;
    end
    chk("drop_strobe_seen", seen, 1);
    @(negedge sclk);
    req1 = 1'b0;
    g = 0;
    for (int i = 0; i < 100 && !g; i++) begin
      @(posedge sclk); #1;
      if (ack[1]) g = 1;
    end
    chk("drop_ack", g, 1);

    // Random traffic on both ports with occasional engine hangs.
    rand_hang_en = 1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 6)) @(negedge sclk);
          port_txn(0, 1'($urandom), 24'($urandom), 8'($urandom), g0, e0, r0);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 6)) @(negedge sclk);
          port_txn(1, 1'($urandom), 24'($urandom), 8'($urandom), g1, e1, r1);
        end
      end
    join
    rand_hang_en = 0;
    repeat (60) @(negedge sclk);
    chk("final_idle", out_v, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
